// File: rtl/btt_pkg.sv
// Shared types, default sizes and width helpers for the branch target table.
package btt_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } btt_state_t;

  localparam int D_DEF     = 12;
  localparam int A_DEF     = 5;
  localparam int BANKS_DEF = 2;
  localparam int CNT_W_DEF = 16;
  localparam int ENTRIES   = BANKS_DEF * (2 ** A_DEF);

  // A single-bank table still gets a 1-bit bank port so the port list stays legal.
  function automatic int bank_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  function automatic int idx_w(input int banks, input int a);
    return $clog2(banks * (2 ** a));
  endfunction

endpackage

// File: rtl/btt_mem.sv
// Target storage with per-entry valid bits: one write/clear port, one sweep-clear
// port and one combinational read port, all addressed by flat index bank*2^A+addr.
module btt_mem
  import btt_pkg::*;
#(
  parameter int D     = D_DEF,
  parameter int A     = A_DEF,
  parameter int BANKS = BANKS_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_wr_en,
  input  logic                         i_wr_clr,
  input  logic [idx_w(BANKS, A)-1:0]   i_wr_idx,
  input  logic [D-1:0]                 i_wr_data,
  input  logic                         i_clr_en,
  input  logic [idx_w(BANKS, A)-1:0]   i_clr_idx,
  input  logic [idx_w(BANKS, A)-1:0]   i_rd_idx,
  output logic [D-1:0]                 o_rd_data,
  output logic                         o_rd_valid
);

  localparam int N_ENT = BANKS * (2 ** A);

  logic [D-1:0]     r_data [N_ENT];
  logic [N_ENT-1:0] r_valid;

  // A clear keeps the stored word; only the valid bit drops.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_wr_clr) begin
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr_en) begin
      r_valid[i_clr_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= !i_wr_clr;
    end
  end

  assign o_rd_data  = r_data[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/branch_target_table.sv
// Multi-bank branch target table: 1-cycle registered lookup with write-first forwarding,
// post-reset valid sweep and saturating miss counter. BTT_REL_EN makes entries PC-relative.
module branch_target_table
  import btt_pkg::*;
#(
  parameter int D     = D_DEF,
  parameter int A     = A_DEF,
  parameter int BANKS = BANKS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_rd_en,
  input  logic [bank_w(BANKS)-1:0]    i_rd_bank,
  input  logic [A-1:0]                i_rd_addr,
`ifdef BTT_REL_EN
  input  logic [D-1:0]                i_pc_in,
`endif
  output logic [D-1:0]                o_target,
  output logic                        o_hit,
  input  logic                        i_wr_en,
  input  logic                        i_wr_clr,
  input  logic [bank_w(BANKS)-1:0]    i_wr_bank,
  input  logic [A-1:0]                i_wr_addr,
  input  logic [D-1:0]                i_wr_data,
  output logic                        o_wr_ready,
  output logic                        o_busy,
  output logic [CNT_W-1:0]            o_miss_count
);

  localparam int N_ENT = BANKS * (2 ** A);
  localparam int IW    = idx_w(BANKS, A);

  btt_state_t       r_state;
  logic [IW-1:0]    r_clr_ptr;
  logic [D-1:0]     r_target;
  logic             r_hit;
  logic [CNT_W-1:0] r_miss;

  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_wr_idx;
  logic          w_wr_acc;
  logic          w_clr_en;
  logic          w_fwd;
  logic [D-1:0]  w_mem_data;
  logic          w_mem_valid;
  logic          w_hit;
  logic [D-1:0]  w_data;
  logic [D-1:0]  w_target;

  assign w_rd_idx = (IW'(i_rd_bank) << A) | IW'(i_rd_addr);
  assign w_wr_idx = (IW'(i_wr_bank) << A) | IW'(i_wr_addr);

  // Index 0 means "no branch", so writes to it never land.
  assign w_wr_acc = i_wr_en && !i_reset && (r_state == ST_READY) && (i_wr_addr != '0);
  assign w_clr_en = !i_reset && (r_state == ST_CLEAR);
  assign w_fwd    = w_wr_acc && (i_wr_bank == i_rd_bank) && (i_wr_addr == i_rd_addr);

  btt_mem #(
    .D     (D),
    .A     (A),
    .BANKS (BANKS)
  ) u_mem (
    .i_clk      (i_clk),
    .i_wr_en    (w_wr_acc),
    .i_wr_clr   (i_wr_clr),
    .i_wr_idx   (w_wr_idx),
    .i_wr_data  (i_wr_data),
    .i_clr_en   (w_clr_en),
    .i_clr_idx  (r_clr_ptr),
    .i_rd_idx   (w_rd_idx),
    .o_rd_data  (w_mem_data),
    .o_rd_valid (w_mem_valid)
  );

  assign w_hit  = w_fwd ? !i_wr_clr
                        : (w_mem_valid && (i_rd_addr != '0) && (r_state == ST_READY));
  assign w_data = w_fwd ? i_wr_data : w_mem_data;

`ifdef BTT_REL_EN
  assign w_target = w_hit ? (i_pc_in + w_data) : '0;
`else
  assign w_target = w_hit ? w_data : '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_target  <= '0;
      r_hit     <= 1'b0;
      r_miss    <= '0;
    end else begin
      if (r_state == ST_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + 1'b1;
        if (r_clr_ptr == IW'(N_ENT - 1)) begin
          r_state <= ST_READY;
        end
      end
      if (i_rd_en) begin
        r_hit    <= w_hit;
        r_target <= w_target;
        if (!w_hit && (r_miss != {CNT_W{1'b1}})) begin
          r_miss <= r_miss + 1'b1;
        end
      end
    end
  end

  assign o_target     = r_target;
  assign o_hit        = r_hit;
  assign o_busy       = (r_state == ST_CLEAR);
  assign o_wr_ready   = (r_state == ST_READY);
  assign o_miss_count = r_miss;

endmodule

// File: tb/tb_branch_target_table.sv
// Bench for branch_target_table: a default DUT plus a CNT_W=2 copy share stimulus and are
// compared each cycle against an array-based model; BTT_REL_EN enables the relative checks.
module tb_branch_target_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic        rd_bank;
  logic [4:0]  rd_addr;
  logic [11:0] pc_in;
  logic        wr_en;
  logic        wr_clr;
  logic        wr_bank;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;

  logic [11:0] t_target;
  logic        t_hit, t_busy, t_wr_ready;
  logic [15:0] t_miss;
  logic [11:0] s_target;
  logic        s_hit, s_busy, s_wr_ready;
  logic [1:0]  s_miss;

  always #5 clk = ~clk;

  branch_target_table u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rd_en      (rd_en),
    .i_rd_bank    (rd_bank),
    .i_rd_addr    (rd_addr),
`ifdef BTT_REL_EN
    .i_pc_in      (pc_in),
`endif
    .o_target     (t_target),
    .o_hit        (t_hit),
    .i_wr_en      (wr_en),
    .i_wr_clr     (wr_clr),
    .i_wr_bank    (wr_bank),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_ready   (t_wr_ready),
    .o_busy       (t_busy),
    .o_miss_count (t_miss)
  );

  branch_target_table #(.CNT_W(2)) u_sat (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rd_en      (rd_en),
    .i_rd_bank    (rd_bank),
    .i_rd_addr    (rd_addr),
`ifdef BTT_REL_EN
    .i_pc_in      (pc_in),
`endif
    .o_target     (s_target),
    .o_hit        (s_hit),
    .i_wr_en      (wr_en),
    .i_wr_clr     (wr_clr),
    .i_wr_bank    (wr_bank),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_ready   (s_wr_ready),
    .o_busy       (s_busy),
    .o_miss_count (s_miss)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: entry contents as plain arrays plus a sweep countdown.
  bit          m_val [2][32];
  logic [11:0] m_dat [2][32];
  bit          m_ready;
  int          m_sweep;
  logic [11:0] e_target;
  bit          e_hit;
  int          e_miss;
  int          e_sat;
`ifdef BTT_REL_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rd_en = 0; rd_bank = 0; rd_addr = 0; pc_in = 0;
    wr_en = 0; wr_clr = 0; wr_bank = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic tick();
    bit          acc, h;
    logic [11:0] d;
    if (reset) begin
      foreach (m_val[b, a]) m_val[b][a] = 0;
      m_ready = 0; m_sweep = 64;
      e_target = 0; e_hit = 0; e_miss = 0; e_sat = 0;
    end else begin
      acc = wr_en && m_ready && (wr_addr != 0);
      if (rd_en) begin
        h = 0; d = 0;
        if (m_ready && rd_addr != 0) begin
          if (acc && wr_bank == rd_bank && wr_addr == rd_addr) begin
            h = !wr_clr; d = wr_data;
          end else begin
            h = m_val[rd_bank][rd_addr]; d = m_dat[rd_bank][rd_addr];
          end
        end
        e_hit = h;
        e_target = h ? (REL ? 12'(pc_in + d) : d) : 12'd0;
        if (!h) begin
          if (e_miss < 65535) e_miss++;
          if (e_sat < 3) e_sat++;
        end
      end
      if (acc) begin
        if (wr_clr) m_val[wr_bank][wr_addr] = 0;
        else begin
          m_val[wr_bank][wr_addr] = 1;
          m_dat[wr_bank][wr_addr] = wr_data;
        end
      end
      if (!m_ready) begin
        m_sweep--;
        if (m_sweep == 0) m_ready = 1;
      end
    end
    @(posedge clk); #1;
    chk("target", t_target, e_target);
    chk("hit", t_hit, e_hit);
    chk("busy", t_busy, !m_ready);
    chk("wr_ready", t_wr_ready, m_ready);
    chk("miss_count", t_miss, e_miss);
    chk("miss_sat", s_miss, e_sat);
    $display("tick t=%0t rd=%0b(%0d,%0d) wr=%0b clr=%0b(%0d,%0d,%0d) -> tgt=%0d hit=%0b busy=%0b miss=%0d sat=%0d",
             $time, rd_en, rd_bank, rd_addr, wr_en, wr_clr, wr_bank, wr_addr, wr_data,
             t_target, t_hit, t_busy, t_miss, s_miss);
  endtask

  typedef struct {
    bit          rd_en;
    bit          rd_bank;
    logic [4:0]  rd_addr;
    bit          wr_en;
    bit          wr_clr;
    bit          wr_bank;
    logic [4:0]  wr_addr;
    logic [11:0] wr_data;
    bit          chk_out;
    bit          x_hit;
    logic [11:0] x_target;
  } vec_t;

  vec_t vt [10];
  int   n;

  initial begin
    vt[0] = '{0, 0, 5'd0, 1, 0, 1, 5'd3, 12'd70,  0, 0, 12'd0};
    vt[1] = '{1, 1, 5'd3, 0, 0, 0, 5'd0, 12'd0,   1, 1, 12'd70};
    vt[2] = '{1, 0, 5'd3, 0, 0, 0, 5'd0, 12'd0,   1, 0, 12'd0};
    vt[3] = '{0, 0, 5'd0, 1, 0, 0, 5'd0, 12'd99,  0, 0, 12'd0};
    vt[4] = '{1, 0, 5'd0, 0, 0, 0, 5'd0, 12'd0,   1, 0, 12'd0};
    vt[5] = '{1, 0, 5'd9, 0, 0, 0, 5'd0, 12'd0,   1, 0, 12'd0};
    vt[6] = '{1, 0, 5'd7, 1, 0, 0, 5'd7, 12'd112, 1, 1, 12'd112};
    vt[7] = '{1, 0, 5'd7, 1, 1, 0, 5'd7, 12'd0,   1, 0, 12'd0};
    vt[8] = '{1, 0, 5'd7, 0, 0, 0, 5'd0, 12'd0,   1, 0, 12'd0};
    vt[9] = '{1, 1, 5'd3, 0, 0, 0, 5'd0, 12'd0,   1, 1, 12'd70};

    idle();
    reset = 1;
    tick(); tick();
    chk("reset_busy", t_busy, 1);
    chk("reset_miss", t_miss, 0);
    reset = 0;

    // Sweep: count cycles with busy high; a lookup and a write are issued mid-sweep.
    n = 0;
    while (t_busy && n < 200) begin
      idle();
      if (n == 3) begin
        rd_en = 1; rd_bank = 0; rd_addr = 5;
        wr_en = 1; wr_bank = 0; wr_addr = 9; wr_data = 55;
      end
      n++;
      tick();
      if (n == 4) begin
        chk("sweep_lookup_hit", t_hit, 0);
        chk("sweep_lookup_miss", t_miss, 1);
      end
    end
    chk("busy_cycles", n, 64);
    idle();

    for (int i = 0; i < 10; i++) begin
      rd_en = vt[i].rd_en; rd_bank = vt[i].rd_bank; rd_addr = vt[i].rd_addr;
      wr_en = vt[i].wr_en; wr_clr = vt[i].wr_clr; wr_bank = vt[i].wr_bank;
      wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
      tick();
      if (vt[i].chk_out) begin
        chk($sformatf("vec%0d_hit", i), t_hit, vt[i].x_hit);
        chk($sformatf("vec%0d_target", i), t_target, vt[i].x_target);
      end
    end
    idle();
    chk("sat_count", s_miss, 3);

`ifdef BTT_REL_EN
    wr_en = 1; wr_bank = 0; wr_addr = 2; wr_data = 12'hFFB;
    tick();
    idle(); rd_en = 1; rd_addr = 2; pc_in = 40;
    tick();
    chk("rel_neg_offset", t_target, 35);
    idle(); wr_en = 1; wr_addr = 4; wr_data = 10;
    tick();
    idle(); rd_en = 1; rd_addr = 4; pc_in = 4090;
    tick();
    chk("rel_wrap", t_target, 4);
    idle();
`endif

    for (int i = 0; i < 400; i++) begin
      rd_en   = ($urandom_range(0, 3) != 0);
      rd_bank = 1'($urandom_range(0, 1));
      rd_addr = 5'($urandom_range(0, 7));
      pc_in   = 12'($urandom);
      wr_en   = ($urandom_range(0, 1) != 0);
      wr_clr  = ($urandom_range(0, 4) == 0);
      wr_bank = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 7));
      wr_data = 12'($urandom);
      tick();
    end

    idle();
    wr_en = 1; wr_bank = 1; wr_addr = 3; wr_data = 70;
    tick();
    idle();
    reset = 1;
    tick();
    chk("midreset_miss", t_miss, 0);
    chk("midreset_busy", t_busy, 1);
    reset = 0;
    for (int i = 0; i < 64; i++) tick();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 8; a++) begin
        rd_en = 1; rd_bank = 1'(b); rd_addr = 5'(a);
        tick();
        chk($sformatf("post_reset_miss_%0d_%0d", b, a), t_hit, 0);
      end
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
